// File: rtl/cip_mubi_sweep_ctrl.sv
// rtl/cip_mubi_sweep_ctrl.sv - mubi lane sweep sequencer: walks each enabled lane through every encoding
module cip_mubi_sweep_ctrl #(
  parameter int                NumMubis  = 4,
  parameter int                Width     = 4,
  parameter logic [Width-1:0]  MubiFalse = 4'h9,
  parameter int                HoldW     = 8,
  localparam int               SelW      = (NumMubis > 1) ? $clog2(NumMubis) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  input  logic                      abort_i,
  input  logic [NumMubis-1:0]       mask_i,
  input  logic [HoldW-1:0]          hold_i,
  output logic [NumMubis*Width-1:0] mubis_o,
  output logic [SelW-1:0]           sel_o,
  output logic [Width-1:0]          val_o,
  output logic                      sample_o,
  output logic                      busy_o,
  output logic                      done_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e                           state_q, state_d;
  logic [NumMubis-1:0]              mask_q, mask_d;
  logic [HoldW-1:0]                 hold_q, hold_d;
  logic [SelW-1:0]                  k_q, k_d;
  logic [Width-1:0]                 v_q, v_d;
  logic [HoldW-1:0]                 cnt_q, cnt_d;

  logic [NumMubis-1:0][Width-1:0]   mubis_q, mubis_d;
  logic [SelW-1:0]                  sel_q, sel_d;
  logic [Width-1:0]                 val_q, val_d;
  logic                             sample_q, sample_d;
  logic                             busy_q, busy_d;
  logic                             done_q, done_d;

  logic [SelW:0]                    first_lane, next_lane;

  // Returns {found, index} of the lowest set bit of m at or above position from.
  function automatic logic [SelW:0] find_from(input logic [NumMubis-1:0] m, input int from);
    logic            found;
    logic [SelW-1:0] idx;
    found = 1'b0;
    idx   = '0;
    for (int i = NumMubis - 1; i >= 0; i--) begin
      if (m[i] && (i >= from)) begin
        found = 1'b1;
        idx   = SelW'(i);
      end
    end
    return {found, idx};
  endfunction

  assign first_lane = find_from(mask_i, 0);
  assign next_lane  = find_from(mask_q, int'(k_q) + 1);

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    hold_d  = hold_q;
    k_d     = k_q;
    v_d     = v_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (start_i && !abort_i) begin
          mask_d = mask_i;
          hold_d = hold_i;
          if (mask_i == '0) begin
            state_d = DONE;
          end else begin
            state_d = DRIVE;
            k_d     = first_lane[SelW-1:0];
            v_d     = '0;
            cnt_d   = '0;
          end
        end
      end
      DRIVE: begin
        // Compare before incrementing so a maximal hold never overflows cnt.
        if (cnt_q == hold_q) begin
          cnt_d = '0;
          if (v_q != '1) begin
            v_d = v_q + Width'(1);
          end else begin
            state_d = GAP;
          end
        end else begin
          cnt_d = cnt_q + HoldW'(1);
        end
      end
      GAP: begin
        if (next_lane[SelW]) begin
          state_d = DRIVE;
          k_d     = next_lane[SelW-1:0];
          v_d     = '0;
          cnt_d   = '0;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort_i && (state_q != IDLE)) begin
      state_d = IDLE;
    end
  end

  // Outputs are decoded from the next state so they line up with it after the edge.
  always_comb begin
    mubis_d  = {NumMubis{MubiFalse}};
    sel_d    = sel_q;
    val_d    = val_q;
    sample_d = 1'b0;
    busy_d   = (state_d == DRIVE) || (state_d == GAP);
    done_d   = (state_d == DONE);
    if (state_d == DRIVE) begin
      mubis_d[k_d] = v_d;
      sel_d        = k_d;
      val_d        = v_d;
      sample_d     = (cnt_d == hold_d);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      hold_q   <= '0;
      k_q      <= '0;
      v_q      <= '0;
      cnt_q    <= '0;
      mubis_q  <= {NumMubis{MubiFalse}};
      sel_q    <= '0;
      val_q    <= '0;
      sample_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      hold_q   <= hold_d;
      k_q      <= k_d;
      v_q      <= v_d;
      cnt_q    <= cnt_d;
      mubis_q  <= mubis_d;
      sel_q    <= sel_d;
      val_q    <= val_d;
      sample_q <= sample_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign mubis_o  = mubis_q;
  assign sel_o    = sel_q;
  assign val_o    = val_q;
  assign sample_o = sample_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_cip_mubi_sweep_ctrl.sv
// tb/tb_cip_mubi_sweep_ctrl.sv - self-checking bench for cip_mubi_sweep_ctrl
module tb_cip_mubi_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [3:0]  mask;
  logic [7:0]  hold;
  logic [15:0] mubis;
  logic [1:0]  sel;
  logic [3:0]  val;
  logic        sample;
  logic        busy;
  logic        done;

  int vectors = 0;
  int miscompares = 0;

  cip_mubi_sweep_ctrl dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (start),
    .abort_i  (abort),
    .mask_i   (mask),
    .hold_i   (hold),
    .mubis_o  (mubis),
    .sel_o    (sel),
    .val_o    (val),
    .sample_o (sample),
    .busy_o   (busy),
    .done_o   (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] mubis;
    logic        busy;
    logic        done;
    logic        sample;
    logic        chk_sel;
    logic [1:0]  sel;
    logic [3:0]  val;
  } exp_t;

  typedef struct {
    logic [3:0] mask;
    logic [7:0] hold;
    int         abort_idx;
    bit         noise;
    int         exp_done_cyc;
    int         exp_samples;
  } case_t;

  exp_t q[$];

  function automatic exp_t idle_rec();
    exp_t e;
    e.mubis = 16'h9999; e.busy = 0; e.done = 0; e.sample = 0;
    e.chk_sel = 0; e.sel = 0; e.val = 0;
    return e;
  endfunction

  // Expected per-cycle trace: lanes in ascending order, each encoding held hold+1 cycles.
  task automatic build(input logic [3:0] m, input logic [7:0] h, input int abort_idx);
    exp_t e;
    q.delete();
    for (int k = 0; k < 4; k++) begin
      if (m[k]) begin
        for (int v = 0; v < 16; v++) begin
          for (int c = 0; c <= int'(h); c++) begin
            e = idle_rec();
            e.mubis[k*4 +: 4] = 4'(v);
            e.busy = 1; e.sample = (c == int'(h));
            e.chk_sel = 1; e.sel = 2'(k); e.val = 4'(v);
            q.push_back(e);
          end
        end
        e = idle_rec();
        e.busy = 1; e.chk_sel = 1; e.sel = 2'(k); e.val = 4'hf;
        q.push_back(e);
      end
    end
    e = idle_rec();
    e.done = 1;
    q.push_back(e);
    q.push_back(idle_rec());
    if (abort_idx >= 0) begin
      while (q.size() > abort_idx + 1) void'(q.pop_back());
      for (int i = 0; i < 3; i++) q.push_back(idle_rec());
    end
  endtask

  task automatic check(input string name, input exp_t e);
    logic bad;
    vectors++;
    bad = (mubis !== e.mubis) || (busy !== e.busy) || (done !== e.done) || (sample !== e.sample);
    if (e.chk_sel) bad = bad || (sel !== e.sel) || (val !== e.val);
    if (bad) begin
      miscompares++;
      $display("FAIL %s: got mubis=%h busy=%b done=%b sample=%b sel=%0d val=%h, want mubis=%h busy=%b done=%b sample=%b sel=%0d val=%h",
               name, mubis, busy, done, sample, sel, val, e.mubis, e.busy, e.done, e.sample, e.sel, e.val);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_case(input string name, input logic [3:0] m, input logic [7:0] h,
                          input int abort_idx, input bit noise,
                          output int done_cyc, output int samples);
    build(m, h, abort_idx);
    mask = m; hold = h; start = 1;
    tick();
    start = 0;
    done_cyc = 0;
    samples = 0;
    for (int i = 0; i < q.size(); i++) begin
      check($sformatf("%s_c%0d", name, i), q[i]);
      if (done) done_cyc = i + 1;
      if (sample) samples++;
      if (noise && (q[i].busy || q[i].done)) begin
        mask = 4'($urandom);
        hold = 8'($urandom);
        start = ($urandom_range(0, 3) == 0);
      end
      if (i == abort_idx) abort = 1;
      tick();
      start = 0;
      abort = 0;
    end
  endtask

  case_t cases[6];
  int dc, ns;
  exp_t rst_e;

  initial begin
    cases[0] = '{4'b0100, 8'd0,   -1, 1'b0, 18,   16};
    cases[1] = '{4'b1001, 8'd2,   -1, 1'b1, 99,   32};
    cases[2] = '{4'b0000, 8'd0,   -1, 1'b0, 1,    0};
    cases[3] = '{4'b0001, 8'd0,   5,  1'b0, 0,    6};
    cases[4] = '{4'b0001, 8'd0,   -1, 1'b0, 18,   16};
    cases[5] = '{4'b1000, 8'd255, -1, 1'b1, 4098, 16};

    rst_n = 0; start = 0; abort = 0; mask = 0; hold = 0;
    rst_e = idle_rec();
    rst_e.chk_sel = 1;
    tick(); tick();
    check("reset_hold", rst_e);
    rst_n = 1;
    tick();
    check("post_reset_idle", idle_rec());

    for (int c = 0; c < 6; c++) begin
      run_case($sformatf("tbl%0d", c), cases[c].mask, cases[c].hold, cases[c].abort_idx,
               cases[c].noise, dc, ns);
      check_int($sformatf("tbl%0d_done_cycle", c), dc, cases[c].exp_done_cyc);
      check_int($sformatf("tbl%0d_samples", c), ns, cases[c].exp_samples);
    end

    start = 1; abort = 1; mask = 4'b1111; hold = 0;
    tick();
    start = 0; abort = 0;
    check("start_abort_idle0", idle_rec());
    tick();
    check("start_abort_idle1", idle_rec());

    for (int r = 0; r < 8; r++) begin
      run_case($sformatf("rnd%0d", r), 4'($urandom), 8'($urandom_range(0, 4)), -1, 1'b1, dc, ns);
    end

    mask = 4'b1111; hold = 8'd1; start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 10; i++) tick();
    #2 rst_n = 0;
    #1 check("reset_mid_sweep", rst_e);
    tick();
    check("reset_mid_sweep_hold", rst_e);
    rst_n = 1;
    tick();
    check("reset_release_idle", idle_rec());

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cip_mubi_sweep_ctrl.md
Name: cip_mubi_sweep_ctrl

Overview:
- Stimulus sequencer for an array of multi-bit-bool (mubi) signals, used to drive a block's mubi inputs for coverage closure.
- On request, walks each enabled mubi lane through all 2^Width encodings, including true, false and every invalid value, one lane at a time.
- All other lanes are parked at the false encoding.
- Emits a sample strobe per value so the monitoring coverage interfaces can be sampled at stable points.
- Sits between a DV test harness (start/abort/config) and the DUT mubi inputs.

Parameters:
- NumMubis, 4, number of mubi lanes driven (1..32).
- Width, 4, bits per mubi lane (2..8).
- MubiFalse, 4'h9 (Width bits), idle/park encoding driven on non-selected lanes and in idle.
- HoldW, 8, width of the hold-count configuration.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  asynchronous active-low reset.
- start_i  input  1  single-cycle request to begin a sweep; ignored unless idle.
- abort_i  input  1  terminate the sweep; priority over all other events.
- mask_i  input  NumMubis  lanes to sweep; sampled with start_i.
- hold_i  input  HoldW  extra cycles each value is held; sampled with start_i.
- mubis_o  output  NumMubis*Width  driven mubi lanes, packed [NumMubis-1:0][Width-1:0].
- sel_o  output  $clog2(NumMubis) (min 1)  index of the lane being swept.
- val_o  output  Width  encoding currently driven on the selected lane.
- sample_o  output  1  pulse on the final hold cycle of each value.
- busy_o  output  1  sweep in progress.
- done_o  output  1  one-cycle pulse on normal completion.

Behaviour:
- All outputs are registered.
- Reset state:
  - FSM in IDLE.
  - Every lane of mubis_o = MubiFalse.
  - sel_o = 0, val_o = 0.
  - sample_o = 0, busy_o = 0, done_o = 0.
  - Internal counters cleared.
- Reset is asynchronous and can occur mid-sweep; it returns immediately to the reset state.
- FSM states: IDLE, DRIVE, GAP, DONE.
- IDLE:
  - start_i=1 latches mask_i into mask_q and hold_i into hold_q.
  - If mask_i==0: go to DONE; done_o=1 in the next cycle and busy_o stays 0.
  - Otherwise: go to DRIVE with k = lowest set bit, v = 0, cnt = 0.
- DRIVE:
  - busy_o=1.
  - mubis_o[k]=v; all other lanes = MubiFalse.
  - sel_o=k, val_o=v.
  - cnt increments each cycle.
  - sample_o=1 exactly when cnt==hold_q.
  - When cnt==hold_q: cnt clears. If v < 2^Width-1, v increments; otherwise go to GAP.
  - Each value is therefore held hold_q+1 cycles.
- GAP:
  - One cycle with all lanes = MubiFalse and busy_o=1.
  - sel_o and val_o keep their last values.
  - Then go to DRIVE on the next set bit of mask_q above k, with v=0.
  - If there is no such bit, go to DONE.
- DONE:
  - done_o=1 and busy_o=0 for one cycle, all lanes MubiFalse.
  - Then go to IDLE.
- Timing: with start sampled at edge t and N set mask bits, the first DRIVE cycle is t+1 and done_o is high in cycle t+1+N*(2^Width*(hold_q+1)+1).
- abort_i:
  - In DRIVE, GAP or DONE, abort_i=1 moves to IDLE on the next edge.
  - That cycle all lanes = MubiFalse, busy_o=0, sample_o=0, done_o=0.
  - No done pulse follows.
  - Abort in IDLE has no effect.
  - Simultaneous start_i and abort_i in IDLE: abort wins and the sweep does not start.
- start_i while busy or in DONE is ignored; mask and hold are not re-latched.
- Mid-sweep changes to mask_i or hold_i have no effect.
- Wrap-around: v counts in a Width+1-bit or explicit compare form, so the value 2^Width-1 is driven and the counter never wraps to 0 within a lane.
- hold_q=0: sample_o is high on every DRIVE cycle.
- hold_q = max (2^HoldW-1): the counter must not overflow.

Test Plan:
- Reset check: hold rst_ni low -> mubis_o all 4'h9, busy_o=0, done_o=0, sample_o=0. Assert reset mid-sweep -> the same values appear immediately.
- Single lane, no hold: start with mask=4'b0100, hold=0 at edge t.
  - Lane 2 shows 0,1,..,15 in cycles t+1..t+16; sample_o high in all 16 cycles.
  - GAP at t+17, done_o at t+18.
  - Other lanes stay 4'h9 throughout.
- Multi-lane with hold: mask=4'b1001, hold=2.
  - Lane 0 is swept first, then lane 3; each value lasts 3 cycles.
  - sample_o is on the third cycle of each value.
  - 32 sample pulses in total; done_o at t+1+2*(16*3+1)=t+99.
- Empty mask: start with mask=0 -> done_o pulse at t+1, busy_o never high, mubis_o unchanged.
- Abort: abort_i during lane 0 value 5 -> next cycle all lanes 4'h9, busy_o=0, no done_o. A fresh start then sweeps from v=0 normally.
- Ignored inputs: a start_i pulse with a different mask issued mid-sweep, plus start and abort asserted together in IDLE -> the sweep is unaffected, and no sweep starts respectively.
